dp_ctrl_fsm: RTL and testbench

//  Controller FSM directly upstream of the Lab 5 datapath; drives every datapath control input.

---
 rtl/dp_ctrl_pkg.sv | 68 ++++++
 rtl/dp_ctrl_fsm_instr_dec.sv | 68 ++++++
 rtl/dp_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_dp_ctrl_fsm.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dp_ctrl_pkg
//   Shared definitions for the Lab 5 datapath controller:
//     - controller state encoding
//     - decoded instruction class
//     - opcode / op field values
//     - ALUop encodings
//     - IR field bit positions
//   No ports (package).
// ---------------------------------------------------------------------------
package dp_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // Decoded instruction class; each class has its own state sequence
    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,  // undefined opcode/op
        CLS_MOV_IMM = 3'd1,  // MOV Rn,#imm8
        CLS_MOV_REG = 3'd2,  // MOV Rd,Rm{,sh}
        CLS_ALU_AB  = 3'd3,  // ADD / AND: both operands, write-back
        CLS_CMP     = 3'd4,  // CMP: both operands, status only
        CLS_MVN     = 3'd5   // MVN: B operand only, write-back
    } instr_cls_t;

    // opcode field values
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field values
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALUop encodings
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // IR field bit positions
    localparam int unsigned IR_OPC_HI = 15;
    localparam int unsigned IR_OPC_LO = 13;
    localparam int unsigned IR_OP_HI  = 12;
    localparam int unsigned IR_OP_LO  = 11;
    localparam int unsigned IR_RN_HI  = 10;
    localparam int unsigned IR_RN_LO  = 8;
    localparam int unsigned IR_RD_HI  = 7;
    localparam int unsigned IR_RD_LO  = 5;
    localparam int unsigned IR_SH_HI  = 4;
    localparam int unsigned IR_SH_LO  = 3;
    localparam int unsigned IR_RM_HI  = 2;
    localparam int unsigned IR_RM_LO  = 0;
    localparam int unsigned IR_IMM_HI = 7;
    localparam int unsigned IR_IMM_LO = 0;

endpackage

// File: rtl/dp_ctrl_fsm_instr_dec.sv
// ---------------------------------------------------------------------------
// instr_dec
//   Combinational decode of the latched 16-bit instruction register.
//   Splits IR into register/shift/op fields, sign-extends imm8 to DATA_W
//   and classifies the instruction (CLS_NOP when undefined).
// Parameters
//   DATA_W  datapath width (>= 9), width of sximm8
// Ports
//   ir      in   16      instruction register
//   op      out  2       op field
//   rn      out  3       Rn field
//   rd      out  3       Rd field
//   sh      out  2       shift field
//   rm      out  3       Rm field
//   sximm8  out  DATA_W  sign-extended imm8
//   cls     out  class   decoded instruction class
//   legal   out  1       1 = defined opcode/op combination
// ---------------------------------------------------------------------------
module instr_dec
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [15:0]       ir,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [1:0]        sh,
    output logic [2:0]        rm,
    output logic [DATA_W-1:0] sximm8,
    output instr_cls_t        cls,
    output logic              legal
);

    logic [2:0] opcode;
    logic [7:0] imm8;

    always_comb begin
        opcode = ir[IR_OPC_HI:IR_OPC_LO];
        op     = ir[IR_OP_HI:IR_OP_LO];
        rn     = ir[IR_RN_HI:IR_RN_LO];
        rd     = ir[IR_RD_HI:IR_RD_LO];
        sh     = ir[IR_SH_HI:IR_SH_LO];
        rm     = ir[IR_RM_HI:IR_RM_LO];
        imm8   = ir[IR_IMM_HI:IR_IMM_LO];
        sximm8 = {{(DATA_W-8){imm8[7]}}, imm8};
    end

    always_comb begin
        cls = CLS_NOP;
        if (opcode == OPC_MOV) begin
            case (op)
                OP_MOV_IMM: cls = CLS_MOV_IMM;
                OP_MOV_REG: cls = CLS_MOV_REG;
                default:    cls = CLS_NOP;
            endcase
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ALU_AB;
                OP_AND:  cls = CLS_ALU_AB;
                OP_CMP:  cls = CLS_CMP;
                default: cls = CLS_MVN;
            endcase
        end
        legal = (cls != CLS_NOP);
    end

endmodule

// File: rtl/dp_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// dp_ctrl_fsm
//   Controller for the Lab 5 datapath. Latches an instruction on a start
//   handshake (s while idle) and sequences regfile read, A/B load,
//   ALU/shift, C/status load and write-back. Supports MOV imm, MOV reg,
//   ADD, CMP, AND, MVN. Undefined instructions retire as NOPs.
//   Outputs are Moore (state and IR only), registered in the FSM block.
//   Datapath load/write enables are additionally gated by ~reset so that a
//   reset cycle never changes datapath state.
// Configuration
//   DP_CTRL_ILLEGAL_EN  adds sticky 'illegal' output, set on decode of an
//                       undefined instruction, cleared only by reset.
// Parameters
//   DATA_W  datapath word width
// Ports
//   clk, reset              clock, synchronous active-high reset
//   s, in                   start request and instruction
//   w                       1 = idle, ready to accept
//   readnum, writenum       regfile read/write selects
//   write, vsel             regfile write enable, 1 = write sximm8
//   loada, loadb            A/B register load enables
//   asel, bsel              1 = ALU A forced to 0; bsel tied 0
//   shift, ALUop            shifter op, ALU op
//   loadc, loads            C / status register load enables
//   datapath_in             sign-extended IR[7:0]
//   illegal (optional)      sticky undefined-instruction flag
// ---------------------------------------------------------------------------
module dp_ctrl_fsm
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [15:0]       in,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              vsel,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic              loadc,
    output logic              loads,
    output logic [DATA_W-1:0] datapath_in
`ifdef DP_CTRL_ILLEGAL_EN
    ,
    output logic              illegal
`endif
);

    state_t      state;
    logic [15:0] ir;

    // Decoded IR fields
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    instr_cls_t  cls;
    logic        legal;

    // Registered output values
    logic        w_q;
    logic [2:0]  readnum_q;
    logic [2:0]  writenum_q;
    logic        write_q;
    logic        vsel_q;
    logic        loada_q;
    logic        loadb_q;
    logic        asel_q;
    logic [1:0]  shift_q;
    logic [1:0]  aluop_q;
    logic        loadc_q;
    logic        loads_q;

    instr_dec #(
        .DATA_W (DATA_W)
    ) u_instr_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (datapath_in),
        .cls    (cls),
        .legal  (legal)
    );

    // Each transition loads the output registers with the values belonging
    // to the state being entered, so outputs stay a function of state/IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_WAIT;
            ir         <= '0;
            w_q        <= 1'b1;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            vsel_q     <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            asel_q     <= 1'b0;
            shift_q    <= '0;
            aluop_q    <= '0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
`ifdef DP_CTRL_ILLEGAL_EN
            illegal    <= 1'b0;
`endif
        end else begin
            w_q        <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            vsel_q     <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            asel_q     <= 1'b0;
            shift_q    <= '0;
            aluop_q    <= '0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;

            case (state)
                S_WAIT: begin
                    if (s) begin
                        ir    <= in;
                        state <= S_DECODE;
                    end else begin
                        w_q   <= 1'b1;
                    end
                end

                S_DECODE: begin
                    if (!legal) begin
                        state <= S_WAIT;
                        w_q   <= 1'b1;
`ifdef DP_CTRL_ILLEGAL_EN
                        illegal <= 1'b1;
`endif
                    end else begin
                        case (cls)
                            CLS_MOV_IMM: begin
                                state      <= S_WRITE_IMM;
                                writenum_q <= rn;
                                vsel_q     <= 1'b1;
                                write_q    <= 1'b1;
                            end
                            CLS_ALU_AB, CLS_CMP: begin
                                state     <= S_GET_A;
                                readnum_q <= rn;
                                loada_q   <= 1'b1;
                            end
                            default: begin
                                // MOV reg / MVN: no A operand needed
                                state     <= S_GET_B;
                                readnum_q <= rm;
                                loadb_q   <= 1'b1;
                            end
                        endcase
                    end
                end

                S_GET_A: begin
                    state     <= S_GET_B;
                    readnum_q <= rm;
                    loadb_q   <= 1'b1;
                end

                S_GET_B: begin
                    state   <= S_EXEC;
                    shift_q <= sh;
                    // MOV reg reuses the adder with A forced to 0
                    aluop_q <= (cls == CLS_MOV_REG) ? ALU_ADD : op;
                    asel_q  <= (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                    loadc_q <= (cls != CLS_CMP);
                    loads_q <= (cls == CLS_CMP);
                end

                S_EXEC: begin
                    if (cls == CLS_CMP) begin
                        state <= S_WAIT;
                        w_q   <= 1'b1;
                    end else begin
                        state      <= S_WRITE_REG;
                        writenum_q <= rd;
                        write_q    <= 1'b1;
                    end
                end

                S_WRITE_IMM, S_WRITE_REG: begin
                    state <= S_WAIT;
                    w_q   <= 1'b1;
                end

                default: begin
                    state <= S_WAIT;
                    w_q   <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w        = w_q;
        readnum  = readnum_q;
        writenum = writenum_q;
        vsel     = vsel_q;
        asel     = asel_q;
        bsel     = 1'b0;
        shift    = shift_q;
        ALUop    = aluop_q;
        // Enables are masked in the reset cycle itself, before the
        // registers above have returned to their reset values.
        write    = write_q & ~reset;
        loada    = loada_q & ~reset;
        loadb    = loadb_q & ~reset;
        loadc    = loadc_q & ~reset;
        loads    = loads_q & ~reset;
    end

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
module tb_dp_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in_r;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic        write, vsel, loada, loadb, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic        loadc, loads;
    logic [15:0] datapath_in;
`ifdef DP_CTRL_ILLEGAL_EN
    logic        illegal;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    dp_ctrl_fsm #(.DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (s),
        .in          (in_r),
        .w           (w),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .loadc       (loadc),
        .loads       (loads),
        .datapath_in (datapath_in)
`ifdef DP_CTRL_ILLEGAL_EN
        ,
        .illegal     (illegal)
`endif
    );

    // Lab 5 datapath model driven by the controller
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] ra = '0, rb = '0, rc = '0;
    logic        z_out = 1'b0;
    logic [15:0] b_sh, a_in, b_in, alu_out;

    always_comb begin
        b_sh = rb;
        case (shift)
            2'b01:   b_sh = {rb[14:0], 1'b0};
            2'b10:   b_sh = {1'b0, rb[15:1]};
            2'b11:   b_sh = {rb[15], rb[15:1]};
            default: b_sh = rb;
        endcase
        a_in = asel ? 16'h0000 : ra;
        b_in = bsel ? 16'h0000 : b_sh;
        case (ALUop)
            2'b00:   alu_out = a_in + b_in;
            2'b01:   alu_out = a_in - b_in;
            2'b10:   alu_out = a_in & b_in;
            default: alu_out = ~b_in;
        endcase
    end

    always @(posedge clk) begin
        if (write) rf[writenum] <= vsel ? datapath_in : rc;
        if (loada) ra <= rf[readnum];
        if (loadb) rb <= rf[readnum];
        if (loadc) rc <= alu_out;
        if (loads) z_out <= (alu_out == 16'h0000);
    end

    // ISA-level reference and scoreboard
    typedef struct {
        logic [15:0]      ir;
        int unsigned      wlow;
        logic [7:0][15:0] regs;
        logic             z;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] sh_rf [8] = '{default: 16'h0000};
    logic        sh_z = 1'b0;

    task automatic ref_push(input logic [15:0] ir);
        exp_t        e;
        logic [15:0] bv, bs, sx;
        bv = sh_rf[ir[2:0]];
        case (ir[4:3])
            2'b01:   bs = bv << 1;
            2'b10:   bs = bv >> 1;
            2'b11:   bs = {bv[15], bv[15:1]};
            default: bs = bv;
        endcase
        sx = {{8{ir[7]}}, ir[7:0]};
        case (ir[15:11])
            5'b11010: begin sh_rf[ir[10:8]] = sx;                          e.wlow = 2; end
            5'b11000: begin sh_rf[ir[7:5]]  = bs;                          e.wlow = 4; end
            5'b10100: begin sh_rf[ir[7:5]]  = sh_rf[ir[10:8]] + bs;        e.wlow = 5; end
            5'b10110: begin sh_rf[ir[7:5]]  = sh_rf[ir[10:8]] & bs;        e.wlow = 5; end
            5'b10101: begin sh_z = ((sh_rf[ir[10:8]] - bs) == 16'h0000);   e.wlow = 4; end
            5'b10111: begin sh_rf[ir[7:5]]  = ~bs;                         e.wlow = 4; end
            default:  e.wlow = 1;
        endcase
        e.ir = ir;
        for (int i = 0; i < 8; i++) e.regs[i] = sh_rf[i];
        e.z = sh_z;
        sb.push_back(e);
    endtask

    task automatic check_result(input int unsigned wlow_obs);
        exp_t e;
        int   bad;
        e = sb.pop_front();
        checks++;
        if (wlow_obs !== e.wlow) begin
            failures++;
            $display("FAIL wlow ir=%h: got %0d expected %0d", e.ir, wlow_obs, e.wlow);
        end
        checks++;
        bad = -1;
        for (int i = 0; i < 8; i++) if (bad < 0 && rf[i] !== e.regs[i]) bad = i;
        if (bad >= 0) begin
            failures++;
            $display("FAIL regfile ir=%h: R%0d got %h expected %h", e.ir, bad, rf[bad], e.regs[bad]);
        end
        checks++;
        if (z_out !== e.z) begin
            failures++;
            $display("FAIL z_out ir=%h: got %b expected %b", e.ir, z_out, e.z);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (w !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (w !== 1'b1) begin
            checks++; failures++;
            $display("FAIL idle_timeout: w got %b expected 1", w);
        end
    endtask

    // Counts w-low cycles after accept; returns at the negedge where w is high
    task automatic count_busy(input logic pulse_s, output int unsigned n);
        n = 0;
        while (w === 1'b0 && n < 20) begin
            n++;
            if (n == 1) begin
                checks++;
                if ({write, loada, loadb, loadc, loads} !== 5'b0) begin
                    failures++;
                    $display("FAIL decode_enables: got %b expected 00000",
                             {write, loada, loadb, loadc, loads});
                end
            end
            if (pulse_s && n == 2) begin s = 1'b1; in_r = 16'hD7FF; end
            if (pulse_s && n == 3) s = 1'b0;
            @(negedge clk);
        end
        if (w !== 1'b1) begin
            checks++; failures++;
            $display("FAIL busy_timeout: w got %b expected 1", w);
        end
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic pulse_s);
        int unsigned n;
        wait_idle();
        ref_push(ir);
        s = 1'b1; in_r = ir;
        @(negedge clk);
        s = 1'b0; in_r = 16'hFFFF;
        count_busy(pulse_s, n);
        check_result(n);
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b0; in_r = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if ({w, write, loada, loadb, loadc, loads, vsel, asel, bsel} !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 100000000",
                     {w, write, loada, loadb, loadc, loads, vsel, asel, bsel});
        end
        checks++;
        if ({readnum, writenum, shift, ALUop, datapath_in} !== 26'h0) begin
            failures++;
            $display("FAIL reset_fields: got %h expected 0",
                     {readnum, writenum, shift, ALUop, datapath_in});
        end
`ifdef DP_CTRL_ILLEGAL_EN
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_illegal: got %b expected 0", illegal);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mov_imm();
        run_instr(16'hD007, 1'b0);
        run_instr(16'hD102, 1'b0);
    endtask

    task automatic test_alu();
        run_instr(16'hA148, 1'b0);  // ADD R2,R1,R0,LSL#1
        run_instr(16'hA800, 1'b0);  // CMP R0,R0
        run_instr(16'hB860, 1'b0);  // MVN R3,R0
        run_instr(16'hC081, 1'b0);  // MOV R4,R1
        run_instr(16'hD5FF, 1'b0);  // MOV R5,#-1
        run_instr(16'hB6E0, 1'b0);  // AND R7,R6,R0 (R6=0)
    endtask

    task automatic test_s_ignored();
        run_instr(16'hA148, 1'b1);
    endtask

    task automatic test_back_to_back();
        int unsigned n;
        wait_idle();
        ref_push(16'hD311);
        ref_push(16'hD422);
        s = 1'b1; in_r = 16'hD311;
        @(negedge clk);
        n = 0;
        while (w === 1'b0 && n < 20) begin n++; @(negedge clk); end
        in_r = 16'hD422;
        #1;
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL moore_w: got %b expected 1", w);
        end
        @(negedge clk);
        checks++;
        if (w !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: w got %b expected 0", w);
        end
        check_result(n);
        s = 1'b0;
        n = 1;
        @(negedge clk);
        while (w === 1'b0 && n < 20) begin n++; @(negedge clk); end
        check_result(n);
    endtask

    task automatic test_reset_mid();
        run_instr(16'hD2AA, 1'b0);  // R2 = FFAA
        s = 1'b1; in_r = 16'hA148;
        @(negedge clk);
        s = 1'b0;
        repeat (3) @(negedge clk);  // DECODE, GET_A, GET_B -> now EXEC
        reset = 1'b1;
        #1;
        checks++;
        if ({w, loadc, write} !== 3'b000) begin
            failures++;
            $display("FAIL reset_gate: {w,loadc,write} got %b expected 000", {w, loadc, write});
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_w: got %b expected 1", w);
        end
        @(negedge clk);
        checks++;
        if (rf[2] !== 16'hFFAA || w !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_r2: R2 got %h w got %b expected FFAA 1", rf[2], w);
        end
    endtask

    task automatic test_illegal();
        run_instr(16'hE000, 1'b0);
`ifdef DP_CTRL_ILLEGAL_EN
        checks++;
        if (illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_set: got %b expected 1", illegal);
        end
`endif
        run_instr(16'hC800, 1'b0);  // MOV with op=01: undefined
        run_instr(16'hD611, 1'b0);
`ifdef DP_CTRL_ILLEGAL_EN
        checks++;
        if (illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_sticky: got %b expected 1", illegal);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: got %b expected 0", illegal);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_alu();
        test_s_ignored();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
